// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: round-robin arbiter sharing the SDRAM controller host port between two bus masters,
// with a post-transfer idle gap, configuration gating and a completion watchdog.
module sdram_port_arbiter #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cfg_done,
  input  logic [19:1] a_m_addr,
  input  logic [15:0] a_m_data_out,
  input  logic        a_m_wr_en,
  input  logic [1:0]  a_m_bytesel,
  input  logic        a_m_access,
  output logic [15:0] a_m_data_in,
  output logic        a_m_ack,
  input  logic [19:1] b_m_addr,
  input  logic [15:0] b_m_data_out,
  input  logic        b_m_wr_en,
  input  logic [1:0]  b_m_bytesel,
  input  logic        b_m_access,
  output logic [15:0] b_m_data_in,
  output logic        b_m_ack,
  output logic        cs,
  output logic [19:1] h_addr,
  output logic [15:0] h_wdata,
  output logic        h_wr_en,
  output logic [1:0]  h_bytesel,
  input  logic [15:0] h_rdata,
  input  logic        h_compl,
  output logic        timeout_err
);
  typedef enum logic [1:0] {IDLE, BUSY_A, BUSY_B, GAP} state_t;
  state_t      state_q, state_d;
  logic        last_b_q, last_b_d;
  logic [15:0] wd_q, wd_d;
  logic        terr_q, terr_d;
  logic        sel_a, sel_b, tc, done;
  logic [15:0] rdata;
  assign sel_a = state_q == BUSY_A;
  assign sel_b = state_q == BUSY_B;
  assign tc    = wd_q == 16'(TIMEOUT - 1);
  assign done  = h_compl || tc;
  // a real completion beats a simultaneous watchdog expiry
  assign rdata = h_compl ? h_rdata : 16'hffff;
  always_comb begin
    state_d  = state_q;
    last_b_d = last_b_q;
    wd_d     = wd_q;
    terr_d   = terr_q;
    case (state_q)
      IDLE: begin
        wd_d = '0;
        if (cfg_done && (a_m_access || b_m_access))
          state_d = (a_m_access && (!b_m_access || last_b_q)) ? BUSY_A : BUSY_B;
      end
      BUSY_A, BUSY_B: begin
        wd_d = wd_q + 16'd1;
        if (done) begin
          state_d  = GAP;
          last_b_d = sel_b;
          terr_d   = terr_q || !h_compl;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      last_b_q <= 1'b1;
      wd_q     <= '0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_b_q <= last_b_d;
      wd_q     <= wd_d;
      terr_q   <= terr_d;
    end
  end
  assign cs          = sel_a || sel_b;
  assign h_addr      = sel_a ? a_m_addr : sel_b ? b_m_addr : '0;
  assign h_wdata     = sel_a ? a_m_data_out : sel_b ? b_m_data_out : '0;
  assign h_wr_en     = sel_a ? a_m_wr_en : sel_b ? b_m_wr_en : 1'b0;
  assign h_bytesel   = sel_a ? a_m_bytesel : sel_b ? b_m_bytesel : '0;
  assign a_m_ack     = sel_a && done;
  assign b_m_ack     = sel_b && done;
  assign a_m_data_in = a_m_ack ? rdata : '0;
  assign b_m_data_in = b_m_ack ? rdata : '0;
  assign timeout_err = terr_q;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: directed scenario bench for sdram_port_arbiter built with an 8-cycle watchdog.
module tb_sdram_port_arbiter;
  logic        clk = 1'b0;
  logic        reset_n, cfg_done;
  logic [19:1] a_m_addr, b_m_addr;
  logic [15:0] a_m_data_out, b_m_data_out, a_m_data_in, b_m_data_in;
  logic        a_m_wr_en, b_m_wr_en, a_m_access, b_m_access, a_m_ack, b_m_ack;
  logic [1:0]  a_m_bytesel, b_m_bytesel;
  logic        cs, h_wr_en, h_compl, timeout_err;
  logic [19:1] h_addr;
  logic [15:0] h_wdata, h_rdata;
  logic [1:0]  h_bytesel;
  int          passed = 0;
  int          total = 0;

  sdram_port_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_done(cfg_done),
    .a_m_addr(a_m_addr), .a_m_data_out(a_m_data_out), .a_m_wr_en(a_m_wr_en),
    .a_m_bytesel(a_m_bytesel), .a_m_access(a_m_access), .a_m_data_in(a_m_data_in), .a_m_ack(a_m_ack),
    .b_m_addr(b_m_addr), .b_m_data_out(b_m_data_out), .b_m_wr_en(b_m_wr_en),
    .b_m_bytesel(b_m_bytesel), .b_m_access(b_m_access), .b_m_data_in(b_m_data_in), .b_m_ack(b_m_ack),
    .cs(cs), .h_addr(h_addr), .h_wdata(h_wdata), .h_wr_en(h_wr_en), .h_bytesel(h_bytesel),
    .h_rdata(h_rdata), .h_compl(h_compl), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // inputs change 1 after the rising edge; checks happen 1 later still, far from any edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; cfg_done = 1'b0; h_compl = 1'b0; h_rdata = '0;
    a_m_addr = '0; a_m_data_out = '0; a_m_wr_en = 1'b0; a_m_bytesel = '0; a_m_access = 1'b0;
    b_m_addr = '0; b_m_data_out = '0; b_m_wr_en = 1'b0; b_m_bytesel = '0; b_m_access = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    total++; if ({cs, a_m_ack, b_m_ack, timeout_err} !== 4'b0) $display("FAIL reset_ctl got %b want 0000", {cs, a_m_ack, b_m_ack, timeout_err}); else passed++;
    total++; if ({h_addr, h_wdata, h_wr_en, h_bytesel, a_m_data_in, b_m_data_in} !== '0) $display("FAIL reset_data got %h want 0", {h_addr, h_wdata, h_wr_en, h_bytesel, a_m_data_in, b_m_data_in}); else passed++;
  endtask

  task automatic test_single_read();
    int acks;
    do_reset();
    cfg_done = 1'b1;
    tick();
    a_m_access = 1'b1; a_m_addr = 19'h00100; h_compl = 1'b1;
    settle();
    total++; if (a_m_ack !== 1'b0) $display("FAIL compl_in_idle got %b want 0", a_m_ack); else passed++;
    h_compl = 1'b0;
    acks = 0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 4) begin h_compl = 1'b1; h_rdata = 16'h1234; end
      settle();
      total++; if (cs !== 1'b1) $display("FAIL read_cs c%0d got %b want 1", c, cs); else passed++;
      if (c < 4) acks += int'(a_m_ack) + int'(b_m_ack);
    end
    total++; if (h_addr !== 19'h00100) $display("FAIL read_addr got %h want 00100", h_addr); else passed++;
    total++; if ({a_m_ack, a_m_data_in, b_m_ack} !== {1'b1, 16'h1234, 1'b0}) $display("FAIL read_ack got %b/%h/%b want 1/1234/0", a_m_ack, a_m_data_in, b_m_ack); else passed++;
    total++; if (acks !== 0) $display("FAIL read_early_ack got %0d want 0", acks); else passed++;
    tick();
    h_compl = 1'b0; a_m_access = 1'b0;
    settle();
    total++; if ({cs, a_m_ack, h_addr} !== '0) $display("FAIL read_gap got %b/%b/%h want 0", cs, a_m_ack, h_addr); else passed++;
    tick();
  endtask

  task automatic test_contention();
    logic exp_a;
    do_reset();
    cfg_done = 1'b1;
    a_m_addr = 19'h00001; b_m_addr = 19'h00002;
    a_m_access = 1'b1; b_m_access = 1'b1;
    exp_a = 1'b1;
    for (int t = 0; t < 4; t++) begin
      tick();
      h_compl = 1'b1; h_rdata = 16'(t);
      settle();
      total++; if ({cs, h_addr} !== {1'b1, exp_a ? 19'h00001 : 19'h00002}) $display("FAIL cont_grant t%0d got %b/%h want A=%b", t, cs, h_addr, exp_a); else passed++;
      total++; if ({a_m_ack, b_m_ack} !== {exp_a, !exp_a}) $display("FAIL cont_ack t%0d got %b%b want %b%b", t, a_m_ack, b_m_ack, exp_a, !exp_a); else passed++;
      tick();
      h_compl = 1'b0;
      settle();
      total++; if (cs !== 1'b0) $display("FAIL cont_gap t%0d got %b want 0", t, cs); else passed++;
      tick();
      settle();
      total++; if (cs !== 1'b0) $display("FAIL cont_idle t%0d got %b want 0", t, cs); else passed++;
      exp_a = !exp_a;
    end
    a_m_access = 1'b0; b_m_access = 1'b0;
    tick(); h_compl = 1'b1; tick(); h_compl = 1'b0; tick(); tick();
  endtask

  task automatic test_write_mux();
    do_reset();
    cfg_done = 1'b1;
    a_m_addr = 19'h11111; a_m_data_out = 16'h1111; a_m_wr_en = 1'b0; a_m_bytesel = 2'b01;
    b_m_addr = 19'h22222; b_m_data_out = 16'hbeef; b_m_wr_en = 1'b1; b_m_bytesel = 2'b10; b_m_access = 1'b1;
    tick();
    settle();
    total++; if ({cs, h_addr, h_wdata, h_wr_en, h_bytesel} !== {1'b1, 19'h22222, 16'hbeef, 1'b1, 2'b10}) $display("FAIL wr_mux got %b/%h/%h/%b/%b want 1/22222/beef/1/10", cs, h_addr, h_wdata, h_wr_en, h_bytesel); else passed++;
    tick();
    h_compl = 1'b1; h_rdata = 16'h0f0f;
    settle();
    total++; if ({b_m_ack, b_m_data_in, a_m_ack, a_m_data_in} !== {1'b1, 16'h0f0f, 1'b0, 16'h0}) $display("FAIL wr_ack got %b/%h/%b/%h want 1/0f0f/0/0000", b_m_ack, b_m_data_in, a_m_ack, a_m_data_in); else passed++;
    tick();
    h_compl = 1'b0; b_m_access = 1'b0;
    tick();
  endtask

  task automatic test_cfg_gating();
    int hi;
    do_reset();
    a_m_access = 1'b1; a_m_addr = 19'h00300;
    hi = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      settle();
      hi += int'(cs);
    end
    total++; if (hi !== 0) $display("FAIL cfg_block got %0d cs-high cycles want 0", hi); else passed++;
    cfg_done = 1'b1;
    tick();
    settle();
    total++; if (cs !== 1'b1) $display("FAIL cfg_grant got %b want 1", cs); else passed++;
    cfg_done = 1'b0;
    tick();
    h_compl = 1'b1; h_rdata = 16'h7777;
    settle();
    total++; if ({a_m_ack, a_m_data_in} !== {1'b1, 16'h7777}) $display("FAIL cfg_drop_busy got %b/%h want 1/7777", a_m_ack, a_m_data_in); else passed++;
    tick();
    h_compl = 1'b0; a_m_access = 1'b0;
    tick();
  endtask

  task automatic test_watchdog();
    int early;
    do_reset();
    cfg_done = 1'b1;
    a_m_access = 1'b1; a_m_addr = 19'h00400;
    early = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      settle();
      if (c < 8) early += int'(a_m_ack) + int'(timeout_err);
    end
    total++; if (early !== 0) $display("FAIL wd_early got %0d want 0", early); else passed++;
    total++; if ({cs, a_m_ack, a_m_data_in} !== {1'b1, 1'b1, 16'hffff}) $display("FAIL wd_ack got %b/%b/%h want 1/1/ffff", cs, a_m_ack, a_m_data_in); else passed++;
    tick();
    a_m_access = 1'b0;
    settle();
    total++; if ({timeout_err, a_m_ack, cs} !== 3'b100) $display("FAIL wd_err got %b want 100", {timeout_err, a_m_ack, cs}); else passed++;
    tick();
    b_m_access = 1'b1; b_m_addr = 19'h00500;
    tick();
    h_compl = 1'b1; h_rdata = 16'h5a5a;
    settle();
    total++; if ({b_m_ack, b_m_data_in, timeout_err} !== {1'b1, 16'h5a5a, 1'b1}) $display("FAIL wd_next_b got %b/%h/%b want 1/5a5a/1", b_m_ack, b_m_data_in, timeout_err); else passed++;
    tick();
    h_compl = 1'b0; b_m_access = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    b_m_access = 1'b1; b_m_addr = 19'h00600;
    tick();
    reset_n = 1'b0;
    settle();
    total++; if (cs !== 1'b1) $display("FAIL rst_mid_busy got %b want 1", cs); else passed++;
    tick();
    reset_n = 1'b1;
    a_m_access = 1'b1; a_m_addr = 19'h00700;
    settle();
    total++; if ({cs, b_m_ack, timeout_err} !== 3'b000) $display("FAIL rst_mid got %b want 000", {cs, b_m_ack, timeout_err}); else passed++;
    tick();
    settle();
    total++; if ({cs, h_addr} !== {1'b1, 19'h00700}) $display("FAIL rst_first_a got %b/%h want 1/00700", cs, h_addr); else passed++;
  endtask

  task automatic test_compl_at_terminal();
    for (int c = 2; c <= 8; c++) begin
      tick();
      if (c == 8) begin h_compl = 1'b1; h_rdata = 16'h1111; end
    end
    settle();
    total++; if ({a_m_ack, a_m_data_in} !== {1'b1, 16'h1111}) $display("FAIL tc_compl got %b/%h want 1/1111", a_m_ack, a_m_data_in); else passed++;
    tick();
    h_compl = 1'b0; a_m_access = 1'b0; b_m_access = 1'b0;
    settle();
    total++; if (timeout_err !== 1'b0) $display("FAIL tc_err got %b want 0", timeout_err); else passed++;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_write_mux();
    test_cfg_gating();
    test_watchdog();
    test_reset_mid();
    test_compl_at_terminal();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
